// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encodings and operand-signedness helpers.
package muldiv_unit_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CALC = ST_CALC,
    S_DONE = ST_DONE
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit connection, with master (pipeline) and
// slave (unit) views plus the FSM state for observation.
interface muldiv_unit_if #(parameter int XLEN = 32) ();
  import muldiv_unit_pkg::*;

  // Handshake: the pipeline raises start with op/operands for an instruction
  // and keeps it until it sees busy=0; the accepting edge is the one where
  // the unit is idle, start=1 and flush=0. done marks the single cycle in
  // which result is valid, and busy is already 0 in that cycle.
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  state_t          dbg_state;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, done, result, dbg_state
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, done, result, dbg_state
  );

endinterface

// File: rtl/muldiv_abs.sv
// Operand sign conditioning: magnitude plus sign flag, with the sign only
// honoured when the operand is to be treated as signed.
module muldiv_abs #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_val,
  input  logic            i_signed,
  output logic [XLEN-1:0] o_mag,
  output logic            o_neg
);

  assign o_neg = i_signed & i_val[XLEN-1];
  assign o_mag = o_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring
// divide on magnitudes. Optional MULDIV_FAST_MUL_EN gives single-cycle MUL*.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_done;

  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg_a;
  logic            w_neg_b;

  muldiv_abs #(.XLEN(XLEN)) u_abs_a (
    .i_val    (bus.operand_a),
    .i_signed (op_a_signed(bus.op)),
    .o_mag    (w_mag_a),
    .o_neg    (w_neg_a)
  );

  muldiv_abs #(.XLEN(XLEN)) u_abs_b (
    .i_val    (bus.operand_b),
    .i_signed (op_b_signed(bus.op)),
    .o_mag    (w_mag_b),
    .o_neg    (w_neg_b)
  );

  logic            w_accept;
  logic            w_is_div;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_res_neg;
  logic [XLEN-1:0] w_special_res;

  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_is_div   = bus.op[2];
  assign w_div_zero = w_is_div && (bus.operand_b == '0);
  assign w_div_ovf  = w_is_div && !bus.op[0] && (bus.operand_a == MIN_NEG) &&
                      (bus.operand_b == '1);
  // Remainders follow the dividend's sign; everything else is sign-xor.
  assign w_res_neg  = (w_is_div && bus.op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = bus.op[1] ? bus.operand_a : '1;
    end else if (w_div_ovf) begin
      w_special_res = bus.op[1] ? '0 : MIN_NEG;
    end
  end

  logic            w_fast_take;
  logic [XLEN-1:0] w_fast_res;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] w_fa;
  logic signed [2*XLEN-1:0] w_fb;
  logic signed [2*XLEN-1:0] w_fprod;
  assign w_fa        = {{XLEN{op_a_signed(bus.op) & bus.operand_a[XLEN-1]}}, bus.operand_a};
  assign w_fb        = {{XLEN{op_b_signed(bus.op) & bus.operand_b[XLEN-1]}}, bus.operand_b};
  assign w_fprod     = w_fa * w_fb;
  assign w_fast_take = !w_is_div;
  assign w_fast_res  = (bus.op == OP_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
  assign w_fast_take = 1'b0;
  assign w_fast_res  = '0;
`endif

  // One iteration: r_hi is remainder / product-high, r_lo is quotient /
  // multiplier-low (shifting), r_b is divisor / multiplicand.
  logic [XLEN:0]   w_rem_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_next_hi;
  logic [XLEN-1:0] w_next_lo;

  assign w_rem_shift = {r_hi, r_lo[XLEN-1]};
  assign w_diff      = w_rem_shift - {1'b0, r_b};
  assign w_sum       = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  always_comb begin
    w_next_hi = r_hi;
    w_next_lo = r_lo;
    if (r_op[2]) begin
      if (!w_diff[XLEN]) begin
        w_next_hi = w_diff[XLEN-1:0];
        w_next_lo = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_next_hi = w_rem_shift[XLEN-1:0];
        w_next_lo = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_next_hi = w_sum[XLEN:1];
      w_next_lo = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod = r_neg ? -{w_next_hi, w_next_lo} : {w_next_hi, w_next_lo};
  assign w_quo  = r_neg ? -w_next_lo : w_next_lo;
  assign w_rem  = r_neg ? -w_next_hi : w_next_hi;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                       w_final = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (bus.flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_op  <= bus.op;
            r_neg <= w_res_neg;
            r_hi  <= '0;
            r_lo  <= w_mag_a;
            r_b   <= w_mag_b;
            r_cnt <= '0;
            if (w_div_zero || w_div_ovf) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else if (w_fast_take) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(XLEN - 1)) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = w_accept || (r_state == S_CALC);
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, flush/reset
// corner sequences and randomized ops against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic clk;
  logic rst;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit / integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    int ia, ib;
    longint sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [63:0] bits;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'b0, a}; ub = {32'b0, b};
    case (op)
      3'd0: begin pu = ua * ub; bits = pu; return bits[31:0]; end
      3'd1: begin p = sa * sb; bits = p; return bits[63:32]; end
      3'd2: begin p = sa * longint'(ub); bits = p; return bits[63:32]; end
      3'd3: begin pu = ua * ub; bits = pu; return bits[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  // Starts at a negedge with the unit idle; returns at the negedge after done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, input string name);
    int cyc;
    bit seen;
    bit busy_ok;
    logic [31:0] got;
    logic [31:0] exp;
    exp_q.push_back(model(op, a, b));
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.flush = 1'b0;
    #1;
    check({name, "_busy_accept"}, 32'(bus.busy), 32'd1);
    cyc = 0; seen = 1'b0; busy_ok = 1'b1; got = '0;
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
        got  = bus.result;
        if (bus.busy) busy_ok = 1'b0;
        bus.start = 1'b0;
      end else begin
        if (!bus.busy && hold) busy_ok = 1'b0;
        if (hold) begin
          bus.operand_a = $urandom;
          bus.operand_b = $urandom;
          bus.op        = 3'($urandom_range(0, 7));
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    exp = exp_q.pop_front();
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL %s_timeout actual=no_done expected=done_by_cycle_%0d", name,
               exp_latency(op, a, b));
      bus.start = 1'b0;
      return;
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_latency(op, a, b)));
    check({name, "_result"}, got, exp);
    check({name, "_busy"}, 32'(busy_ok), 32'd1);
    last_exp = exp;
    @(negedge clk);
    check({name, "_done_drop"}, 32'(bus.done), 32'd0);
    check({name, "_result_hold"}, bus.result, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return MIN_NEG;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t vecs[18];

  initial begin
    bit no_done;
    vecs[0]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14};
    vecs[1]  = '{OP_REMU,   32'd100,       32'd7,         32'd2};
    vecs[2]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[3]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_REM,    32'd5,         32'd0,         32'd5};
    vecs[6]  = '{OP_DIV,    MIN_NEG,       32'hFFFF_FFFF, MIN_NEG};
    vecs[7]  = '{OP_REM,    MIN_NEG,       32'hFFFF_FFFF, 32'd0};
    vecs[8]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{OP_REMU,   32'd5,         32'd0,         32'd5};
    vecs[10] = '{OP_MULH,   MIN_NEG,       MIN_NEG,       32'h4000_0000};
    vecs[11] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[12] = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    vecs[13] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
    vecs[14] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    vecs[15] = '{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[16] = '{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[17] = '{OP_DIVU,   MIN_NEG,       32'hFFFF_FFFF, 32'd0};

    bus.start = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_result", bus.result, 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_busy_idle", 32'(bus.busy), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    bus.start = 1'b1;
    #1;
    check("reset_busy_start", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    last_exp = 32'd0;
    @(negedge clk);

    // Table: model cross-checks the hand-derived expectations too.
    foreach (vecs[i]) begin
      check($sformatf("vec%0d_model", i), model(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, i[0], $sformatf("vec%0d", i));
    end

    // flush and start together in IDLE: flush wins.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd9; bus.operand_b = 32'd3;
    #1;
    check("prio_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("prio_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("prio_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0; bus.flush = 1'b0;

    // Flush at cycle 10 of a DIVU, restart at cycle 12.
    bus.start = 1'b1; bus.op = OP_DIVU; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
    no_done = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) no_done = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    if (bus.done) no_done = 1'b0;
    check("flush_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_no_done", 32'(no_done), 32'd1);
    check("flush_result_hold", bus.result, last_exp);
    @(negedge clk);
    run_op(OP_DIVU, 32'd1000, 32'd3, 1'b0, "after_flush");

    // Reset in the middle of CALC: abort silently, result cleared.
    bus.start = 1'b1; bus.op = OP_REMU; bus.operand_a = 32'd12345; bus.operand_b = 32'd17;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("midreset_result", bus.result, 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) no_done = 1'b0;
    end
    check("midreset_no_done", 32'(no_done), 32'd1);
    last_exp = 32'd0;

    // Randomized ops, sometimes holding start with changing operands.
    for (int n = 0; n < 150; n++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL expose parameter XLEN, default 32, meaning the operand and result width.
REQ-002 The block SHALL expose port clk, input, width 1, meaning the single core clock, rising-edge active.
REQ-003 The block SHALL expose port rst, input, width 1, meaning reset, synchronous, active-high.
REQ-004 The block SHALL expose port start, input, width 1, meaning the EX stage holds a valid RV32M instruction.
REQ-005 The block SHALL expose port op, input, width 3, meaning funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-006 The block SHALL expose port operand_a, input, width XLEN, meaning the post-forwarding rs1 value.
REQ-007 The block SHALL expose port operand_b, input, width XLEN, meaning the post-forwarding rs2 value.
REQ-008 The block SHALL expose port flush, input, width 1, meaning the EX instruction is squashed.
REQ-009 The block SHALL expose port busy, output, width 1, meaning the pipeline stall request.
REQ-010 The block SHALL expose port done, output, width 1, meaning result is valid this cycle.
REQ-011 The block SHALL expose port result, output, width XLEN, meaning the RV32M result.

Function
REQ-012 States SHALL be IDLE, CALC, DONE.
REQ-013 IDLE with start=1 and flush=0 SHALL latch op, the operand magnitudes, the result-sign and the special-case flags.
REQ-014 On that latch, IDLE SHALL go to CALC; for the divide special cases it SHALL go directly to DONE.
REQ-015 CALC SHALL perform exactly 32 iterations, one bit per cycle: restoring division for DIV/REM, shift-add for MUL.
REQ-016 CALC SHALL go to DONE after its 32nd iteration.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE; start is ignored in DONE.
REQ-018 busy SHALL equal (state==IDLE && start && !flush) || state==CALC; busy SHALL be 0 in DONE, letting the pipeline advance at that edge.
REQ-019 done SHALL be 1 only in DONE, and result SHALL be valid only when done=1.
REQ-020 result SHALL hold its last value when done=0.
REQ-021 Latency: start accepted at cycle 0 SHALL give CALC in cycles 1..32 and DONE in cycle 33.
REQ-022 Latency for the divide special cases SHALL be DONE in cycle 1.
REQ-023 Division by zero SHALL give quotient all-ones and remainder = operand_a, for both signed and unsigned ops.
REQ-024 Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF) SHALL give quotient 0x80000000 and remainder 0.
REQ-025 Signed ops SHALL operate on magnitudes, with sign fix-up applied when entering DONE.
REQ-026 The remainder SHALL take the dividend's sign; MULHSU SHALL treat only operand_a as signed.
REQ-027 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU SHALL return the high XLEN bits.
REQ-028 flush=1 in any state SHALL force IDLE at the next edge, with done=0 and result unchanged.
REQ-029 flush takes priority over start.
REQ-030 start held high during CALC SHALL not restart the operation; operand changes during CALC SHALL be ignored.

Reset
REQ-031 rst=1 at a clock edge SHALL force state to IDLE and clear result, the internal accumulators and the counter to 0.
REQ-032 Reset mid-CALC SHALL abort the operation with no done pulse.
REQ-033 Outputs after reset SHALL be busy=start, done=0, result=0.

Configuration
REQ-034 Macro MULDIV_FAST_MUL_EN defined: MUL* ops SHALL use a single-cycle combinational 33x33 signed multiplier, with IDLE going directly to DONE (done in cycle 1).
REQ-035 Macro MULDIV_FAST_MUL_EN undefined: MUL* ops SHALL use the 32-cycle iterative path.
REQ-036 Division SHALL be iterative in both configurations.

Structure
REQ-037 The funct3 op encodings and the state encodings SHALL be localparams in the shared core definitions header.
REQ-038 Sub-module muldiv_abs SHALL provide operand sign conditioning (absolute value plus sign flag, signed or unsigned selectable) and SHALL be instantiated twice.

Verification
REQ-039 DIVU 100/7 -> done at cycle 33, result=14; repeating with REMU -> result=2.
REQ-040 DIV 0xFFFFFFF9 (-7) / 2 -> result=0xFFFFFFFD (-3); REM -> result=0xFFFFFFFF (-1).
REQ-041 DIV 5/0 -> done at cycle 1, result=0xFFFFFFFF; REM 5/0 -> result=5; DIV 0x80000000/0xFFFFFFFF -> result=0x80000000.
REQ-042 MULH 0x80000000*0x80000000 -> result=0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> result=0xFFFFFFFE; MUL -> result=1.
REQ-043 Flush at cycle 10 of DIVU -> IDLE at cycle 11, no done pulse; a new start at cycle 12 -> correct result at cycle 45.
REQ-044 Run the full suite with and without MULDIV_FAST_MUL_EN -> identical results; MUL done at cycle 1 with the macro, at cycle 33 without.
